// File: rtl/clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// clock_mode_ctrl
//
// Mode controller for a simple clock/stopwatch display. It conditions four
// asynchronous operator inputs (2-flop synchronizer + debouncer each), detects
// button presses, and runs a RUN / PAUSED / ADJUST state machine that decides
// which tick reaches the time counter and which display field is adjusted.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   tick_1hz      1 Hz one-cycle pulse (synchronous to clk)
//   tick_2hz      2 Hz one-cycle pulse (synchronous to clk)
//   pause_raw     pause pushbutton, 1 = pressed (asynchronous)
//   clr_raw       clear pushbutton, 1 = pressed (asynchronous)
//   adj_raw       adjust switch, 1 = adjust (asynchronous)
//   sel_raw       select switch, 1 = seconds, 0 = minutes (asynchronous)
//   tick_active   one-cycle tick to the time counter
//   count_enable  high while running
//   use_2hz       high while adjusting
//   sel_minutes   minutes field is being adjusted
//   sel_seconds   seconds field is being adjusted
//   blink         blank phase for the selected field
//   clr_pulse     one-cycle clear request to the time counter
//   mode          00 RUN, 01 PAUSED, 10 ADJUST
// ---------------------------------------------------------------------------
module clock_mode_ctrl #(
  parameter int DB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_raw,
  input  logic       clr_raw,
  input  logic       adj_raw,
  input  logic       sel_raw,
  output logic       tick_active,
  output logic       count_enable,
  output logic       use_2hz,
  output logic       sel_minutes,
  output logic       sel_seconds,
  output logic       blink,
  output logic       clr_pulse,
  output logic [1:0] mode
);

  localparam int               CNT_W  = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);

  // Bit positions of the conditioned inputs.
  localparam int I_PAUSE = 0;
  localparam int I_CLR   = 1;
  localparam int I_ADJ   = 2;
  localparam int I_SEL   = 3;
  localparam int N_IN    = 4;

  // Encoding matches the mode output directly.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJUST = 2'b10
  } state_e;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [N_IN-1:0] raw_vec;
  logic [N_IN-1:0] sync1_q, sync2_q;

  assign raw_vec = {sel_raw, adj_raw, clr_raw, pause_raw};

  // Two flops per input: the first may go metastable, the second gives it a
  // full cycle to resolve before anything else looks at it.
  // NOTE: sequential state is written with <= so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
    end
  end

  logic [N_IN-1:0]  db_q, db_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];

  // The counter measures how long the synced value has disagreed with the
  // debounced value; any agreement restarts the measurement.
  // NOTE: every variable gets its default before the conditional logic, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (cnt_d[i] == DB_MAX) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end
      end
    end
  end

  // NOTE: the per-input counters are a handful of flops, not a RAM, so they
  // are cleared by reset like every other register; a mid-debounce reset
  // must not leave a partial count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A press is the cycle in which the debounced value is about to rise, so
  // the FSM reacts on the same edge the debounced level changes.
  logic pause_press, clr_press, adj_db, sel_db;

  assign pause_press = db_d[I_PAUSE] & ~db_q[I_PAUSE];
  assign clr_press   = db_d[I_CLR]   & ~db_q[I_CLR];
  assign adj_db      = db_q[I_ADJ];
  assign sel_db      = db_q[I_SEL];

  // -------------------------------------------------------------------------
  // Mode FSM
  // -------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   saved_run_q, saved_run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      saved_run_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      saved_run_q <= saved_run_d;
    end
  end

  // The adjust switch outranks a pause press; a press landing on the entry
  // cycle flips the remembered return mode instead of the current state.
  always_comb begin
    state_d     = state_q;
    saved_run_d = saved_run_q;
    case (state_q)
      ST_RUN: begin
        if (adj_db) begin
          state_d     = ST_ADJUST;
          saved_run_d = ~pause_press;
        end else if (pause_press) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (adj_db) begin
          state_d     = ST_ADJUST;
          saved_run_d = pause_press;
        end else if (pause_press) begin
          state_d = ST_RUN;
        end
      end
      ST_ADJUST: begin
        // Toggle first, then use the updated flag for the exit decision.
        saved_run_d = saved_run_q ^ pause_press;
        if (!adj_db) state_d = saved_run_d ? ST_RUN : ST_PAUSED;
      end
      default: begin
        state_d     = ST_RUN;
        saved_run_d = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they all move on the
  // same edge as mode.
  // -------------------------------------------------------------------------
  logic tick_active_q, tick_active_d;
  logic count_enable_q, count_enable_d;
  logic use_2hz_q, use_2hz_d;
  logic sel_minutes_q, sel_minutes_d;
  logic sel_seconds_q, sel_seconds_d;
  logic blink_q, blink_d;
  logic clr_pulse_q, clr_pulse_d;

  always_comb begin
    use_2hz_d      = (state_d == ST_ADJUST);
    count_enable_d = (state_d == ST_RUN);
    sel_seconds_d  = use_2hz_d &  sel_db;
    sel_minutes_d  = use_2hz_d & ~sel_db;
    // PAUSED still forwards the 1 Hz tick; the counter gates it itself.
    tick_active_d  = use_2hz_d ? tick_2hz : tick_1hz;
    // Blink restarts from the visible phase on entry and idles low elsewhere.
    blink_d        = (use_2hz_d && state_q == ST_ADJUST) ? (blink_q ^ tick_2hz) : 1'b0;
    clr_pulse_d    = clr_press;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_active_q  <= 1'b0;
      count_enable_q <= 1'b1;
      use_2hz_q      <= 1'b0;
      sel_minutes_q  <= 1'b0;
      sel_seconds_q  <= 1'b0;
      blink_q        <= 1'b0;
      clr_pulse_q    <= 1'b0;
    end else begin
      tick_active_q  <= tick_active_d;
      count_enable_q <= count_enable_d;
      use_2hz_q      <= use_2hz_d;
      sel_minutes_q  <= sel_minutes_d;
      sel_seconds_q  <= sel_seconds_d;
      blink_q        <= blink_d;
      clr_pulse_q    <= clr_pulse_d;
    end
  end

  assign tick_active  = tick_active_q;
  assign count_enable = count_enable_q;
  assign use_2hz      = use_2hz_q;
  assign sel_minutes  = sel_minutes_q;
  assign sel_seconds  = sel_seconds_q;
  assign blink        = blink_q;
  assign clr_pulse    = clr_pulse_q;
  assign mode         = state_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_mode_ctrl
//
// Scoreboard bench for clock_mode_ctrl with DB_CYCLES = 4. A reference model
// runs on every rising edge and queues the expected output vector; a monitor
// on the falling edge pops and compares it against the DUT. The model treats
// debouncing as "the last DB_CYCLES synchronized samples all disagree with
// the debounced level" over a history of raw samples, and the mode logic as
// plain integer bookkeeping. Directed scenarios are followed by random
// button/switch activity; ticks are random throughout.
// ---------------------------------------------------------------------------
module tb_clock_mode_ctrl;

  localparam int       DB        = 4;
  localparam logic [8:0] RESET_VEC = 9'b00_1_0_0_0_0_0_0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, tick_2hz;
  logic       pause_raw, clr_raw, adj_raw, sel_raw;
  logic       tick_active, count_enable, use_2hz;
  logic       sel_minutes, sel_seconds, blink, clr_pulse;
  logic [1:0] mode;

  clock_mode_ctrl #(.DB_CYCLES(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .tick_2hz     (tick_2hz),
    .pause_raw    (pause_raw),
    .clr_raw      (clr_raw),
    .adj_raw      (adj_raw),
    .sel_raw      (sel_raw),
    .tick_active  (tick_active),
    .count_enable (count_enable),
    .use_2hz      (use_2hz),
    .sel_minutes  (sel_minutes),
    .sel_seconds  (sel_seconds),
    .blink        (blink),
    .clr_pulse    (clr_pulse),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  // {mode, count_enable, use_2hz, sel_minutes, sel_seconds, blink, tick_active, clr_pulse}
  logic [8:0] dut_vec;
  assign dut_vec = {mode, count_enable, use_2hz, sel_minutes, sel_seconds,
                    blink, tick_active, clr_pulse};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [8:0] exp_q [$];
  logic [3:0] raw_hist [$];   // raw samples from previous edges, newest last
  logic [3:0] m_db;
  int         m_mode;         // 0 RUN, 1 PAUSED, 2 ADJUST
  bit         m_saved;
  bit         m_blink;

  task automatic model_reset();
    raw_hist.delete();
    for (int k = 0; k < DB + 2; k++) raw_hist.push_back(4'b0000);
    m_db    = 4'b0000;
    m_mode  = 0;
    m_saved = 1'b1;
    m_blink = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
        exp_q.push_back(RESET_VEC);
      end else begin
        logic [3:0] raw_now, new_db;
        bit pp, cp, adj, sel, t1, t2, use2;
        int old_mode, n;
        raw_now = {sel_raw, adj_raw, clr_raw, pause_raw};
        t1 = tick_1hz;
        t2 = tick_2hz;
        n  = raw_hist.size();
        // The debouncer sees the raw value from two edges ago; it flips once
        // DB consecutive such samples disagree with the current level.
        new_db = m_db;
        for (int i = 0; i < 4; i++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int k = 1; k <= DB; k++)
            if (raw_hist[n-1-k][i] == m_db[i]) all_diff = 1'b0;
          if (all_diff) new_db[i] = ~m_db[i];
        end
        pp  = new_db[0] & ~m_db[0];
        cp  = new_db[1] & ~m_db[1];
        adj = m_db[2];
        sel = m_db[3];
        m_db = new_db;

        old_mode = m_mode;
        case (old_mode)
          0: if (adj) begin m_mode = 2; m_saved = !pp; end
             else if (pp) m_mode = 1;
          1: if (adj) begin m_mode = 2; m_saved = pp; end
             else if (pp) m_mode = 0;
          default: begin
            m_saved = m_saved ^ pp;
            if (!adj) m_mode = m_saved ? 0 : 1;
          end
        endcase
        use2    = (m_mode == 2);
        m_blink = (use2 && old_mode == 2) ? (m_blink ^ t2) : 1'b0;

        exp_q.push_back({2'(m_mode), m_mode == 0, use2, use2 & !sel, use2 & sel,
                         m_blink, use2 ? t2 : t1, cp});

        raw_hist.push_back(raw_now);
        if (raw_hist.size() > DB + 4) void'(raw_hist.pop_front());
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  int         mode_changes = 0;
  int         clr_high     = 0;
  logic [1:0] prev_mode    = 2'b00;
  int         cyc          = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) check($sformatf("outputs cyc %0d", cyc), dut_vec, exp_q.pop_front());
      if (mode !== prev_mode) mode_changes++;
      prev_mode = mode;
      if (clr_pulse === 1'b1) clr_high++;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    forever begin
      @(negedge clk);
      tick_2hz = ($urandom_range(0, 3) == 0);
      tick_1hz = ($urandom_range(0, 7) == 0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_pause();
    pause_raw = 1'b1; wait_cyc(10);
    pause_raw = 1'b0; wait_cyc(10);
  endtask

  initial begin
    int snap;
    rst_n = 1'b0;
    pause_raw = 1'b0; clr_raw = 1'b0; adj_raw = 1'b0; sel_raw = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;

    // Idle in RUN with 1 Hz ticks passing through.
    wait_cyc(30);

    // Bouncy pause press: only one RUN->PAUSED transition, release is silent.
    snap = mode_changes;
    pause_raw = 1'b1; wait_cyc(2);
    pause_raw = 1'b0; wait_cyc(1);
    pause_raw = 1'b1; wait_cyc(10);
    pause_raw = 1'b0; wait_cyc(12);
    check("bounce_mode_changes", 9'(mode_changes - snap), 9'd1);

    // ADJUST from PAUSED, minutes then seconds; pause toggles the return to RUN.
    adj_raw = 1'b1; sel_raw = 1'b0; wait_cyc(30);
    sel_raw = 1'b1; wait_cyc(20);
    press_pause();
    adj_raw = 1'b0; wait_cyc(15);

    // From RUN: ADJUST, one press, clear held 20 cycles, exit lands in PAUSED.
    adj_raw = 1'b1; sel_raw = 1'b0; wait_cyc(15);
    press_pause();
    snap = clr_high;
    clr_raw = 1'b1; wait_cyc(20);
    clr_raw = 1'b0; wait_cyc(10);
    check("clr_pulse_width", 9'(clr_high - snap), 9'd1);
    adj_raw = 1'b0; wait_cyc(15);

    // Back to RUN, then ADJUST with no press returns to RUN.
    press_pause();
    adj_raw = 1'b1; wait_cyc(15);
    adj_raw = 1'b0; wait_cyc(15);

    // Reset in the middle of ADJUST while blink is high.
    adj_raw = 1'b1; wait_cyc(10);
    for (int k = 0; k < 300 && !m_blink; k++) @(negedge clk);
    if (!m_blink) begin
      errors++; checks++;
      $display("FAIL blink_wait: blink never rose within budget");
    end else begin
      check("blink_before_reset", {8'b0, blink}, 9'd1);
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", dut_vec, RESET_VEC);
    adj_raw = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(10);

    // Random operator activity, including glitches shorter than the debounce.
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(0, 3))
        0: pause_raw = ~pause_raw;
        1: clr_raw   = ~clr_raw;
        2: adj_raw   = ~adj_raw;
        default: sel_raw = ~sel_raw;
      endcase
      wait_cyc($urandom_range(1, 12));
    end
    pause_raw = 1'b0; clr_raw = 1'b0; adj_raw = 1'b0;
    wait_cyc(20);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 1) begin
      errors++; checks++;
      $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
